// File: rtl/pc_sequencer.sv
// Fetch-side PC unit: next-PC selection, interrupt/exception vectoring,
// EPC generation and retired-instruction counting.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic        illegal_op,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_addr,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        irq_ack,
  output logic [31:0] retired
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        irq_pending_q, irq_pending_d;

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic        take_irq;
  logic        take_exc;

  assign pc       = pc_q;
  assign retired  = retired_q;
  assign kernel   = pc_q[31];
  assign pc_plus4 = pc_q + 32'd4;

  assign br_tgt = pc_plus4
                + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {pc_plus4[31:28], target26, 2'b00};
  // jr can leave kernel but never enter it from user mode
  assign jr_tgt = {pc_q[31] & jr_addr[31], jr_addr[30:0]};

  assign take_irq = irq_pending_q & ~kernel & ~stall;
  assign take_exc = illegal_op & ~stall;

  assign epc_we  = take_exc | take_irq;
  assign irq_ack = take_irq & ~take_exc;
  assign epc     = take_exc ? pc_plus4 : pc_q;

  always_comb begin
    pc_d = pc_q;
    if (reset)
      pc_d = RESET_VEC;
    else if (stall)
      pc_d = pc_q;
    else if (take_exc)
      pc_d = EXC_VEC;
    else if (take_irq)
      pc_d = IRQ_VEC;
    else if (is_jr)
      pc_d = jr_tgt;
    else if (is_jump)
      pc_d = j_tgt;
    else if (is_branch & branch_taken)
      pc_d = br_tgt;
    else
      pc_d = pc_plus4;
  end

  always_comb begin
    irq_pending_d = irq_pending_q;
    if (reset)
      irq_pending_d = 1'b0;
    else if (irq)
      irq_pending_d = 1'b1;
    else if (irq_ack)
      irq_pending_d = 1'b0;
  end

  always_comb begin
    retired_d = retired_q;
    if (reset)
      retired_d = 32'd0;
    else if (~stall & ~take_irq)
      retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    pc_q          <= pc_d;
    irq_pending_q <= irq_pending_d;
    retired_q     <= retired_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        is_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic        is_jump = 1'b0;
  logic        is_jr = 1'b0;
  logic        illegal_op = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [31:0] jr_addr = '0;
  logic        irq = 1'b0;
  logic [31:0] pc, pc_plus4, epc, retired;
  logic        kernel, epc_we, irq_ack;

  int total = 0;
  int bad = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .is_branch(is_branch), .branch_taken(branch_taken),
    .is_jump(is_jump), .is_jr(is_jr),
    .illegal_op(illegal_op), .imm16(imm16),
    .target26(target26), .jr_addr(jr_addr), .irq(irq),
    .pc(pc), .pc_plus4(pc_plus4), .kernel(kernel),
    .epc(epc), .epc_we(epc_we), .irq_ack(irq_ack),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural state only
  logic [31:0] m_pc, m_ret;
  bit          m_pend;
  bit          m_ok = 0;

  function automatic bit m_tirq();
    return m_pend && !m_pc[31] && !stall;
  endfunction

  function automatic bit m_texc();
    return illegal_op && !stall;
  endfunction

  always @(posedge clk) begin
    bit ti, te;
    ti = m_tirq();
    te = m_texc();
    if (reset) begin
      m_pc = 32'h8000_0000;
      m_pend = 0;
      m_ret = 0;
      m_ok = 1;
    end else if (m_ok) begin
      m_ret = (!stall && !ti) ? m_ret + 1 : m_ret;
      m_pend = irq ? 1'b1 : ((ti && !te) ? 1'b0 : m_pend);
      if (!stall) begin
        if (te)
          m_pc = 32'h8000_0008;
        else if (ti)
          m_pc = 32'h8000_0004;
        else if (is_jr)
          m_pc = {m_pc[31] & jr_addr[31], jr_addr[30:0]};
        else if (is_jump)
          m_pc = {(m_pc + 32'd4) & 32'hF000_0000}
               | {4'h0, target26, 2'b00};
        else if (is_branch && branch_taken)
          m_pc = m_pc + 4 + (32'(signed'(imm16)) * 4);
        else
          m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      bit ti, te;
      ti = m_tirq();
      te = m_texc();
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("m_kernel", {31'd0, kernel}, {31'd0, m_pc[31]});
      chk("m_epc_we", {31'd0, epc_we}, {31'd0, te | ti});
      chk("m_irq_ack", {31'd0, irq_ack}, {31'd0, ti & !te});
      chk("m_retired", retired, m_ret);
      if (te)
        chk("m_epc_exc", epc, m_pc + 32'd4);
      else if (ti)
        chk("m_epc_irq", epc, m_pc);
    end
  end

  task automatic idle();
    stall = 0; is_branch = 0; branch_taken = 0;
    is_jump = 0; is_jr = 0; illegal_op = 0; reset = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    logic [31:0] r0;
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_ret", retired, 32'd0);
    step(); chk("seq1", pc, 32'h8000_0004);
    step(); chk("seq2", pc, 32'h8000_0008);
    step(); chk("seq3", pc, 32'h8000_000C);
    chk("ret3", retired, 32'd3);

    is_jump = 1; target26 = 26'h2C;
    step(); chk("j_b0", pc, 32'h8000_00B0);
    chk("kern1", {31'd0, kernel}, 32'd1);
    is_jr = 1; jr_addr = 32'h0000_00B4;
    step(); chk("jr_user", pc, 32'h0000_00B4);
    chk("kern0", {31'd0, kernel}, 32'd0);
    is_jr = 1; jr_addr = 32'h8000_0010;
    step(); chk("jr_nokern", pc, 32'h0000_0010);
    chk("kern0b", {31'd0, kernel}, 32'd0);

    is_jump = 1; target26 = 26'h33;
    step(); chk("j_cc", pc, 32'h0000_00CC);
    is_branch = 1; branch_taken = 1; imm16 = 16'hFFFE;
    step(); chk("br_back", pc, 32'h0000_00C8);
    is_jump = 1; target26 = 26'h33;
    step();
    is_jump = 1; target26 = 26'h38;
    step(); chk("j_e0", pc, 32'h0000_00E0);

    is_jump = 1; target26 = 26'h54;
    step(); chk("j_150", pc, 32'h0000_0150);
    irq = 1; #1;
    chk("irq_lat", {31'd0, epc_we}, 32'd0);
    step(); irq = 0; #1;
    chk("irq_pc", pc, 32'h0000_0154);
    chk("irq_we", {31'd0, epc_we}, 32'd1);
    chk("irq_epc", epc, 32'h0000_0154);
    chk("irq_ack", {31'd0, irq_ack}, 32'd1);
    step(); chk("irq_vec", pc, 32'h8000_0004);

    irq = 1;
    step(); chk("nonest1", pc, 32'h8000_0008);
    step(); chk("nonest2", pc, 32'h8000_000C);
    is_jr = 1; jr_addr = 32'h0000_0154;
    step(); irq = 0; #1;
    chk("ret_pc", pc, 32'h0000_0154);
    chk("revec_we", {31'd0, epc_we}, 32'd1);
    step(); chk("revec_pc", pc, 32'h8000_0004);

    is_jr = 1; jr_addr = 32'h0000_0180;
    step(); #1;
    chk("pend_clr", {31'd0, epc_we}, 32'd0);
    is_jump = 1; target26 = 26'h80; irq = 1;
    step(); irq = 0;
    chk("pc_200", pc, 32'h0000_0200);
    illegal_op = 1; #1;
    chk("exc_we", {31'd0, epc_we}, 32'd1);
    chk("exc_epc", epc, 32'h0000_0204);
    chk("exc_noack", {31'd0, irq_ack}, 32'd0);
    step(); chk("exc_vec", pc, 32'h8000_0008);
    is_jr = 1; jr_addr = 32'h0000_0300;
    step(); #1;
    chk("pend_kept", {31'd0, irq_ack}, 32'd1);
    chk("pend_epc", epc, 32'h0000_0300);
    step(); chk("pend_vec", pc, 32'h8000_0004);

    r0 = m_ret;
    stall = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stall_pc", pc, 32'h8000_0004);
    chk("stall_ret", retired, r0);
    chk("stall_we", {31'd0, epc_we}, 32'd0);
    idle();
    step(); step();
    reset = 1;
    step();
    chk("rst_mid_pc", pc, 32'h8000_0000);
    chk("rst_mid_ret", retired, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      stall        = ($urandom_range(0, 9) == 0);
      illegal_op   = ($urandom_range(0, 29) == 0);
      irq          = ($urandom_range(0, 19) == 0);
      is_jr        = ($urandom_range(0, 9) == 0);
      is_jump      = ($urandom_range(0, 9) == 0);
      is_branch    = ($urandom_range(0, 4) == 0);
      branch_taken = $urandom_range(0, 1);
      imm16        = 16'($urandom);
      target26     = 26'($urandom);
      jr_addr      = $urandom;
      @(posedge clk); #1;
    end
    idle();
    irq = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
